// File: rtl/dsi_lane_distributor.sv
// Buffers host words in a short preload FIFO and repacks the byte stream across
// 1..LANES_MAX DSI data lanes. Handles start/fin sequencing, the final-beat byte
// mask, abort and underflow.
module dsi_lane_distributor #(
  parameter int unsigned LANES_MAX     = 4,
  parameter int unsigned BYTE_W        = 8,
  parameter int unsigned PRELOAD_DEPTH = 2
) (
  input  logic                        clk_sys,
  input  logic                        rst_n,
  input  logic [4*BYTE_W-1:0]         iface_write_data,
  input  logic [3:0]                  iface_write_strb,
  input  logic                        iface_write_valid,
  input  logic                        iface_last_word,
  output logic                        iface_write_ready,
  input  logic [1:0]                  reg_lanes_number,
  input  logic                        tx_abort,
  input  logic [LANES_MAX-1:0]        lanes_data_rqst,
  output logic [LANES_MAX*BYTE_W-1:0] lanes_data,
  output logic [LANES_MAX-1:0]        lanes_byte_valid,
  output logic [LANES_MAX-1:0]        lanes_start_rqst,
  output logic [LANES_MAX-1:0]        lanes_fin_rqst,
  output logic                        data_underflow_error
);

  localparam int unsigned WORD_W = 4 * BYTE_W;
  localparam int unsigned ACC_N  = LANES_MAX + 3;
  localparam int unsigned ACC_CW = $clog2(ACC_N + 1);
  localparam int unsigned LN_W   = $clog2(LANES_MAX + 1);
  localparam int unsigned FC_W   = $clog2(PRELOAD_DEPTH + 1);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [2:0]        nbytes;
    logic              last;
  } fifo_entry_t;

  typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_START, S_STREAM, S_FIN} state_t;

  state_t                                state_q, state_d;
  fifo_entry_t [PRELOAD_DEPTH-1:0]       fifo_q, fifo_d;
  logic [FC_W-1:0]                       fifo_cnt_q, fifo_cnt_d;
  logic [ACC_N-1:0][BYTE_W-1:0]          acc_q, acc_d;
  logic [ACC_CW-1:0]                     acc_cnt_q, acc_cnt_d;
  logic                                  acc_last_q, acc_last_d;
  logic                                  last_acc_q, last_acc_d;
  logic [LN_W-1:0]                       lanes_n_q, lanes_n_d;

  logic                        ready_d, underflow_d;
  logic [LANES_MAX*BYTE_W-1:0] data_d;
  logic [LANES_MAX-1:0]        valid_d, start_d, fin_d;

  logic        accept, consume, refill_en, refill, flush;
  fifo_entry_t head, new_entry;
  int unsigned ln_q, cnt_q, req_n, consumed, rem, fifo_left, ln_d, cnt_d;

  logic unused_rqst;
  assign unused_rqst = ^lanes_data_rqst;

  // Next-state: sequencing, accumulator repacking, FIFO and output beat
  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    acc_d       = '0;
    acc_last_d  = acc_last_q;
    last_acc_d  = last_acc_q;
    lanes_n_d   = lanes_n_q;
    underflow_d = 1'b0;
    refill_en   = 1'b0;
    flush       = 1'b0;
    data_d      = '0;
    valid_d     = '0;
    start_d     = '0;
    fin_d       = '0;

    accept  = iface_write_valid && iface_write_ready && !tx_abort && (state_q != S_FIN);
    consume = lanes_data_rqst[0] && (state_q == S_STREAM) && !tx_abort;
    ln_q    = 32'(lanes_n_q);
    cnt_q   = 32'(acc_cnt_q);
    req_n   = 32'(reg_lanes_number) + 1;
    if (req_n > LANES_MAX) req_n = LANES_MAX;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_PRELOAD;
          lanes_n_d = LN_W'(req_n);
        end
      end
      S_PRELOAD: begin
        if (tx_abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if ((32'(fifo_cnt_q) == PRELOAD_DEPTH) || last_acc_q) begin
          state_d   = S_START;
          refill_en = 1'b1;
        end
      end
      S_START: begin
        if (tx_abort) begin
          flush   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d   = S_STREAM;
          refill_en = 1'b1;
        end
      end
      S_STREAM: begin
        if (tx_abort) begin
          flush   = 1'b1;
          state_d = S_FIN;
        end else if (consume && (cnt_q == 0) && !acc_last_q) begin
          underflow_d = 1'b1;
          flush       = 1'b1;
          state_d     = S_FIN;
        end else if (consume && acc_last_q && (cnt_q <= ln_q)) begin
          state_d = S_FIN;
        end else begin
          refill_en = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        flush   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Drop the consumed beat, then append one FIFO word behind the leftovers
    consumed = consume ? ((cnt_q < ln_q) ? cnt_q : ln_q) : 0;
    rem      = cnt_q - consumed;
    head     = fifo_q[0];
    refill   = refill_en && (rem < ln_q) && (fifo_cnt_q != '0);
    for (int j = 0; j < ACC_N; j++) begin
      for (int k = 0; k < ACC_N; k++) begin
        if (32'(k) == 32'(j) + consumed) acc_d[j] = acc_q[k];
      end
      for (int k = 0; k < 4; k++) begin
        if (refill && (32'(j) == rem + 32'(k))) acc_d[j] = head.data[k*BYTE_W +: BYTE_W];
      end
    end
    acc_cnt_d  = ACC_CW'(rem + (refill ? 32'(head.nbytes) : 0));
    acc_last_d = acc_last_q || (refill && head.last);

    // Preload FIFO: pop shifts down, push lands behind the survivors
    new_entry.data = iface_write_data;
    new_entry.last = iface_last_word;
    if (!iface_last_word) begin
      new_entry.nbytes = 3'd4;
    end else begin
      case (iface_write_strb)
        4'b0001: new_entry.nbytes = 3'd1;
        4'b0011: new_entry.nbytes = 3'd2;
        4'b0111: new_entry.nbytes = 3'd3;
        default: new_entry.nbytes = 3'd4;
      endcase
    end
    fifo_left = 32'(fifo_cnt_q) - (refill ? 1 : 0);
    if (refill) begin
      for (int i = 0; i < PRELOAD_DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
    end
    if (accept) begin
      for (int i = 0; i < PRELOAD_DEPTH; i++) begin
        if (32'(i) == fifo_left) fifo_d[i] = new_entry;
      end
    end
    fifo_cnt_d = FC_W'(fifo_left + (accept ? 1 : 0));
    if (accept && iface_last_word) last_acc_d = 1'b1;

    if (flush) begin
      fifo_cnt_d = '0;
      acc_d      = '0;
      acc_cnt_d  = '0;
      acc_last_d = 1'b0;
      last_acc_d = 1'b0;
    end

    // Output beat and pulses reflect the state being entered
    ln_d  = 32'(lanes_n_d);
    cnt_d = 32'(acc_cnt_d);
    for (int i = 0; i < LANES_MAX; i++) begin
      valid_d[i] = (32'(i) < ln_d) && (32'(i) < cnt_d);
      data_d[i*BYTE_W +: BYTE_W] = valid_d[i] ? acc_d[i] : '0;
      start_d[i] = (32'(i) < ln_d) && (state_d == S_START);
      fin_d[i]   = (32'(i) < ln_d) && (state_d == S_FIN);
    end
    ready_d = (32'(fifo_cnt_d) < PRELOAD_DEPTH) && !last_acc_d && (state_d != S_FIN);
  end

  // State and registered outputs
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= S_IDLE;
      fifo_q               <= '0;
      fifo_cnt_q           <= '0;
      acc_q                <= '0;
      acc_cnt_q            <= '0;
      acc_last_q           <= 1'b0;
      last_acc_q           <= 1'b0;
      lanes_n_q            <= LN_W'(1);
      iface_write_ready    <= 1'b1;
      lanes_data           <= '0;
      lanes_byte_valid     <= '0;
      lanes_start_rqst     <= '0;
      lanes_fin_rqst       <= '0;
      data_underflow_error <= 1'b0;
    end else begin
      state_q              <= state_d;
      fifo_q               <= fifo_d;
      fifo_cnt_q           <= fifo_cnt_d;
      acc_q                <= acc_d;
      acc_cnt_q            <= acc_cnt_d;
      acc_last_q           <= acc_last_d;
      last_acc_q           <= last_acc_d;
      lanes_n_q            <= lanes_n_d;
      iface_write_ready    <= ready_d;
      lanes_data           <= data_d;
      lanes_byte_valid     <= valid_d;
      lanes_start_rqst     <= start_d;
      lanes_fin_rqst       <= fin_d;
      data_underflow_error <= underflow_d;
    end
  end

endmodule
